// File: rtl/apb_modport.sv
// APB3/APB4 completer register bank. Word 0 is a read-only ID and the upper half is privileged.
// Each access takes a fixed number of wait states. PRDATA, PREADY and PSLVERR are registered.
module apb_modport #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_REGS    = 16,
    parameter int unsigned       WAIT_STATES = 0,
    parameter bit                APB4        = 1'b1,
    parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(32'hA9B0_0001)
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFS    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;

    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                priv_q;
    logic [DATA_W-1:0]   mem_q [NUM_REGS];

    logic                latch_c;
    logic                commit_c;
    logic                ready_now_c;
    logic [ADDR_W-1:0]   cur_addr_c;
    logic                cur_write_c;
    logic                cur_priv_c;
    logic [IDX_W-1:0]    cur_idx_c;
    logic                err_c;
    logic [DATA_W-1:0]   rdata_c;
    logic [IDX_W-1:0]    idx_q_c;
    logic [STRB_W-1:0]   wmask_c;
    logic                unused_prot;

    assign unused_prot = ^PPROT[2:1];

    // In IDLE the live bus is decoded so a zero-wait access can respond on its setup edge.
    always_comb begin
        cur_addr_c  = (state_q == IDLE) ? PADDR   : addr_q;
        cur_write_c = (state_q == IDLE) ? PWRITE  : write_q;
        cur_priv_c  = (state_q == IDLE) ? PPROT[0] : priv_q;
        cur_idx_c   = IDX_W'(cur_addr_c >> OFS);
        err_c       = ((cur_addr_c & ADDR_W'(STRB_W - 1)) != '0)
                   || ((cur_addr_c >> (OFS + IDX_W)) != '0)
                   || (cur_write_c && (cur_idx_c == '0))
                   || (APB4 && !cur_priv_c && (cur_idx_c >= IDX_W'(NUM_REGS / 2)));
        rdata_c     = (cur_idx_c == '0) ? ID_VALUE : mem_q[cur_idx_c];
        idx_q_c     = IDX_W'(addr_q >> OFS);
        wmask_c     = APB4 ? strb_q : '1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pready_d    = pready_q;
        pslverr_d   = pslverr_q;
        prdata_d    = prdata_q;
        latch_c     = 1'b0;
        commit_c    = 1'b0;
        ready_now_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d     = ACCESS;
                    latch_c     = 1'b1;
                    cnt_d       = CNT_W'(WAIT_STATES);
                    pready_d    = 1'b0;
                    pslverr_d   = 1'b0;
                    ready_now_c = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (PENABLE && pready_q) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    commit_c  = write_q && !pslverr_q;
                end else if (cnt_q != '0) begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    ready_now_c = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        if (ready_now_c) begin
            pready_d  = 1'b1;
            pslverr_d = err_c;
            if (!cur_write_c) begin
                prdata_d = err_c ? '0 : rdata_c;
            end
        end
    end

    // Control, output and request-capture registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            priv_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (latch_c) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
                priv_q  <= PPROT[0];
            end
        end
    end

    // Register storage. It is written only on an error-free write completion.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit_c) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wmask_c[b]) begin
                    mem_q[idx_q_c][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_modport.sv
// Scoreboard bench for apb_modport. It drives four instances that differ in wait states
// and APB3/APB4 mode through a shared bus, with a separate PSEL for each instance.
module tb_apb_modport;

    localparam int NDUT = 4;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        preset;
    logic [3:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [NDUT];
    logic [3:0]  pready;
    logic [3:0]  pslverr;

    logic [31:0] model [NDUT][16];
    logic [31:0] last_rd [NDUT];
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    apb_modport #(.WAIT_STATES(0), .APB4(1'b1)) u_dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
    apb_modport #(.WAIT_STATES(0), .APB4(1'b0)) u_dut1 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
    apb_modport #(.WAIT_STATES(3), .APB4(1'b1)) u_dut2 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));
    apb_modport #(.WAIT_STATES(2), .APB4(1'b1)) u_dut3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[3]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3]));

    function automatic int wait_of(input int d);
        case (d)
            2:       return 3;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++) begin
            last_rd[d] = '0;
            for (int i = 0; i < 16; i++) model[d][i] = '0;
        end
    endtask

    // Reference behaviour: update the storage model and queue the expected response.
    task automatic model_push(input int d, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
        exp_t e;
        int   idx;
        bit   apb4;
        bit   err;
        apb4 = (d != 1);
        idx  = int'(addr[5:2]);
        err  = (addr[1:0] != 2'b00) || (addr[31:6] != 26'd0) || (wr && idx == 0)
            || (apb4 && !prot[0] && idx >= 8);
        if (wr) begin
            if (!err) begin
                for (int b = 0; b < 4; b++) begin
                    if (!apb4 || strb[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else begin
            last_rd[d] = err ? 32'h0 : ((idx == 0) ? ID : model[d][idx]);
        end
        e.rdata = last_rd[d];
        e.err   = err;
        e.lat   = 1 + wait_of(d);
        exp_q.push_back(e);
    endtask

    // One complete transfer. The bus is scrambled during the access phase to confirm the request was captured at setup.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
        exp_t e;
        int   lat;
        model_push(d, wr, addr, wdata, strb, prot);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge clk); #1;
        penable = 1'b1; pwrite = ~wr; paddr = ~addr; pwdata = ~wdata; pstrb = ~strb; pprot = ~prot;
        lat = 1;
        while (!pready[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        check($sformatf("latency d%0d a%08h", d, addr), 32'(lat), 32'(e.lat));
        check($sformatf("pslverr d%0d a%08h", d, addr), 32'(pslverr[d]), 32'(e.err));
        check($sformatf("prdata d%0d a%08h", d, addr), prdata[d], e.rdata);
        @(posedge clk); #1;
        check($sformatf("pready_drop d%0d", d), 32'(pready[d]), 32'h0);
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    // Starts a write and drops PSEL before the wait states have elapsed.
    task automatic apb_abort(input int d, input logic [31:0] addr, input logic [31:0] wdata);
        psel[d] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr;
        pwdata = wdata; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("abort_pending", 32'(pready[d]), 32'h0);
        psel[d] = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_ready", 32'(pready[d]), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_pready d%0d", d), 32'(pready[d]), 32'h0);
            check($sformatf("rst_pslverr d%0d", d), 32'(pslverr[d]), 32'h0);
            check($sformatf("rst_prdata d%0d", d), prdata[d], 32'h0);
        end
        preset = 1'b0;
        @(posedge clk); #1;

        // ID read, byte strobes, and back-to-back traffic
        apb_xfer(0, 1'b0, 32'h0,  32'h0,         4'h0,    3'b000);
        apb_xfer(0, 1'b1, 32'h4,  32'hDEADBEEF,  4'b0101, 3'b000);
        apb_xfer(0, 1'b0, 32'h4,  32'h0,         4'h0,    3'b000);
        apb_xfer(1, 1'b1, 32'h4,  32'hDEADBEEF,  4'b0101, 3'b000);
        apb_xfer(1, 1'b0, 32'h4,  32'h0,         4'h0,    3'b000);
        apb_xfer(0, 1'b1, 32'h8,  32'h55AA55AA,  4'b0000, 3'b000);
        apb_xfer(0, 1'b0, 32'h8,  32'h0,         4'h0,    3'b000);

        // wait states
        apb_xfer(2, 1'b1, 32'h8,  32'h12345678,  4'hF,    3'b001);
        apb_xfer(2, 1'b0, 32'h8,  32'h0,         4'h0,    3'b001);

        // error responses
        apb_xfer(0, 1'b1, 32'h0,  32'h11111111,  4'hF,    3'b001);
        apb_xfer(0, 1'b0, 32'h2,  32'h0,         4'h0,    3'b001);
        apb_xfer(0, 1'b0, 32'h40, 32'h0,         4'h0,    3'b001);
        apb_xfer(0, 1'b1, 32'h44, 32'h22222222,  4'hF,    3'b001);
        apb_xfer(0, 1'b1, 32'h20, 32'h33333333,  4'hF,    3'b000);
        apb_xfer(0, 1'b0, 32'h0,  32'h0,         4'h0,    3'b000);
        apb_xfer(0, 1'b0, 32'h20, 32'h0,         4'h0,    3'b001);
        apb_xfer(0, 1'b0, 32'h4,  32'h0,         4'h0,    3'b000);

        // privileged access
        apb_xfer(0, 1'b1, 32'h20, 32'hCAFEF00D,  4'hF,    3'b001);
        apb_xfer(0, 1'b0, 32'h20, 32'h0,         4'h0,    3'b001);
        apb_xfer(0, 1'b0, 32'h20, 32'h0,         4'h0,    3'b000);
        apb_xfer(1, 1'b1, 32'h3C, 32'h0BADF00D,  4'h0,    3'b000);
        apb_xfer(1, 1'b0, 32'h3C, 32'h0,         4'h0,    3'b000);

        // abort while in the access phase
        apb_xfer(3, 1'b1, 32'hC,  32'h11112222,  4'hF,    3'b001);
        apb_abort(3, 32'hC, 32'h99999999);
        apb_xfer(3, 1'b0, 32'hC,  32'h0,         4'h0,    3'b001);

        // PENABLE already high in IDLE is ignored
        psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b001;
        repeat (3) begin
            @(posedge clk); #1;
            check("violation_no_ready", 32'(pready[0]), 32'h0);
        end
        psel[0] = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        apb_xfer(0, 1'b0, 32'h4,  32'h0,         4'h0,    3'b000);

        // reset during a write that is still in its wait states
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        check("midrst_pready", 32'(pready[2]), 32'h0);
        check("midrst_pslverr", 32'(pslverr[2]), 32'h0);
        check("midrst_prdata", prdata[2], 32'h0);
        preset = 1'b0; psel = '0; penable = 1'b0;
        clear_model();
        @(posedge clk); #1;
        apb_xfer(2, 1'b0, 32'h10, 32'h0,         4'h0,    3'b001);
        apb_xfer(2, 1'b1, 32'h10, 32'hA5A5A5A5,  4'hF,    3'b001);
        apb_xfer(2, 1'b0, 32'h10, 32'h0,         4'h0,    3'b001);
        apb_xfer(0, 1'b0, 32'h4,  32'h0,         4'h0,    3'b000);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_modport.md
# apb_modport

APB3/APB4 completer (slave) register bank with configurable wait states, byte strobes and protection checking. It sits behind a single APB select line in the peripheral subsystem and is the reference target for APB VIP regression. The block holds NUM_REGS words of storage. Word 0 is a read-only ID register. The upper half of the bank is privileged.

## Interface
- ADDR_W, 32: PADDR width.
- DATA_W, 32: data width; multiple of 8. STRB_W = DATA_W/8 and OFS = $clog2(STRB_W).
- NUM_REGS, 16: number of data words; power of 2, ≥4.
- WAIT_STATES, 0: wait cycles inserted per access (0–15).
- APB4, 1: 1 = honour PSTRB/PPROT; 0 = APB3 behaviour.
- ID_VALUE, 32'hA9B0_0001: read value of word 0.

Ports:
- PCLK  in  1  clock; all logic on posedge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  STRB_W  byte write strobes.
- PPROT  in  3  protection; bit 0 = privileged.
- PRDATA  out  DATA_W  read data; registered.
- PREADY  out  1  transfer complete; registered.
- PSLVERR  out  1  error response; registered; valid only with PREADY.

## Operation
- FSM states:
  - IDLE → SETUP when PSEL=1 and PENABLE=0 are sampled.
  - SETUP → ACCESS unconditionally.
  - ACCESS → IDLE on the completion edge, which is the edge where PSEL, PENABLE and PREADY are all sampled 1.
  - ACCESS → IDLE if PSEL is sampled 0 (abort). An abort commits no write and drops PREADY.
- PENABLE=1 sampled while in IDLE is a protocol violation. It is ignored: PREADY stays 0 and nothing is written.
- On the SETUP edge, latch PADDR, PWRITE, PWDATA, PSTRB and PPROT. Later changes to the inputs are ignored.
- Index = PADDR[OFS+$clog2(NUM_REGS)-1:OFS].
- The error condition (PSLVERR=1) is any of:
  - PADDR[OFS-1:0] ≠ 0;
  - PADDR bits above the index field are nonzero;
  - a write to index 0;
  - APB4=1, PPROT[0]=0 and index ≥ NUM_REGS/2.
- Write with no error: commit on the completion edge.
  - Each byte i is updated only if PSTRB[i]=1.
  - If APB4=0, all bytes are written.
  - A write with PSTRB=0 is a legal no-op with PSLVERR=0.
- Erroring writes modify nothing.
- Read: PRDATA = ID_VALUE for index 0, otherwise storage[index]. An erroring read returns 0.
- PRDATA is loaded on the same edge that sets PREADY=1 and is held until the next read completion. Writes do not change PRDATA.
- If APB4=0, PPROT and PSTRB are ignored entirely.
- Reset: storage is cleared to 0, FSM goes to IDLE, and PREADY=0, PSLVERR=0, PRDATA=0. Reset overrides any transfer in flight. An interrupted write commits nothing.

## Timing
- Wait counter:
  - Loaded with WAIT_STATES on the SETUP edge.
  - Decremented on each ACCESS edge while it is nonzero.
  - PREADY is registered to 1 on the edge where the counter reaches 0. If WAIT_STATES=0, this is the SETUP edge.
- Transfer length = 2 + WAIT_STATES cycles: 1 setup, 1+WAIT_STATES access.
- PREADY is high for exactly one cycle per transfer and returns to 0 on the edge after completion.
- PSLVERR is set together with PREADY and is cleared with it.
- Back-to-back transfers: a new SETUP may be sampled on the cycle right after completion. There is no idle cycle requirement.
- Reset asserted on any edge forces all outputs to 0 on that edge.

## Test plan
- Reset, then read 0x0 with WAIT_STATES=0 → PREADY high in the 2nd cycle, PRDATA=0xA9B00001, PSLVERR=0.
- Write 0x4 with 0xDEADBEEF, PSTRB=4'b0101, then read 0x4 → 0x00AD00EF. Repeat with APB4=0 → 0xDEADBEEF.
- WAIT_STATES=3, write then read 0x8 → PREADY rises exactly 4 cycles after SETUP. PRDATA matches the written data.
- Error cases, each must give PSLVERR=1 with PREADY, and storage must be unchanged:
  - write 0x0;
  - read 0x2 (unaligned) → PRDATA=0;
  - address 0x40 with NUM_REGS=16;
  - write 0x20 with PPROT=3'b000.
- Write 0x20 with PPROT=3'b001 → no error, and the readback matches the written value.
- Two scenarios must leave the target register at its prior value:
  - PSEL dropped mid-ACCESS with WAIT_STATES=2;
  - PRESET asserted mid-write.
- After either, the next transfer behaves normally.
